// File: rtl/seg7_pkg.sv
// Shared types, segment table and polarity helper for the 7-segment scan driver.
package seg7_pkg;

    typedef enum logic [0:0] {StBlank, StDrive} state_e;

    // Hex-to-segment table, active-high, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SegTable [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] apply_polarity(input logic [6:0] val, input bit active_low);
        return active_low ? ~val : val;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Bundle of scan-tick input, display data and multiplexed display outputs.
interface seg7_scan_driver_if #(
    parameter int unsigned NUM_DIGITS = 4
);

    logic                      i_delayClock;
    logic [4*NUM_DIGITS-1:0]   i_digits;
    logic [NUM_DIGITS-1:0]     i_dp;
    logic [NUM_DIGITS-1:0]     i_enable;
    logic [NUM_DIGITS-1:0]     o_anode;
    logic [6:0]                o_seg;
    logic                      o_dp;
    logic                      o_frame;

    // Source side: supplies the tick and display data, observes the display pins.
    modport master (
        output i_delayClock, i_digits, i_dp, i_enable,
        input  o_anode, o_seg, o_dp, o_frame
    );

    // Scanner side.
    modport slave (
        input  i_delayClock, i_digits, i_dp, i_enable,
        output o_anode, o_seg, o_dp, o_frame
    );

endinterface

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to 7-segment pattern with selectable output polarity.
module seg7_hex_decoder
    import seg7_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = apply_polarity(SegTable[i_nibble], ACTIVE_LOW);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment scanner: one digit per scan tick, optional blanking slots,
// display data latched once per frame.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned BLANK_TICKS = 1,
    parameter bit          ACTIVE_LOW  = 1'b1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    seg7_scan_driver_if.slave  bus
);

    localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CntW = (BLANK_TICKS > 1) ? $clog2(BLANK_TICKS) : 1;

    localparam logic [IdxW-1:0]       IdxLast  = IdxW'(NUM_DIGITS - 1);
    localparam logic [CntW-1:0]       CntLast  = (BLANK_TICKS == 0) ? '0 : CntW'(BLANK_TICKS - 1);
    localparam logic [NUM_DIGITS-1:0] AnodeOff = ACTIVE_LOW ? '1 : '0;
    localparam logic [6:0]            SegOff   = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic                  DpOff    = ACTIVE_LOW;

    logic                      d1_q;
    logic                      tick;
    state_e                    state_q, state_d;
    logic [IdxW-1:0]           idx_q, idx_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0]   sh_dig_q, sh_dig_d;
    logic [NUM_DIGITS-1:0]     sh_dp_q, sh_dp_d;
    logic [NUM_DIGITS-1:0]     anode_q, anode_d;
    logic [6:0]                seg_q, seg_d;
    logic                      dp_q, dp_d;
    logic                      frame_q, frame_d;
    logic                      wrap;
    logic                      latch;
    logic [3:0]                nibble;
    logic [6:0]                seg_dec;
    logic [NUM_DIGITS-1:0]     anode_on;

    // The divided clock is treated purely as data; a rising edge is one scan tick.
    assign tick = bus.i_delayClock & ~d1_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            d1_q     <= 1'b0;
            state_q  <= StBlank;
            idx_q    <= '0;
            cnt_q    <= '0;
            sh_dig_q <= '0;
            sh_dp_q  <= '0;
            anode_q  <= AnodeOff;
            seg_q    <= SegOff;
            dp_q     <= DpOff;
            frame_q  <= 1'b0;
        end else begin
            d1_q     <= bus.i_delayClock;
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            sh_dig_q <= sh_dig_d;
            sh_dp_q  <= sh_dp_d;
            anode_q  <= anode_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            frame_q  <= frame_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        wrap    = 1'b0;
        if (tick) begin
            unique case (state_q)
                StBlank: begin
                    if (BLANK_TICKS == 0 || cnt_q == CntLast) begin
                        state_d = StDrive;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StDrive: begin
                    wrap    = (idx_q == IdxLast);
                    idx_d   = wrap ? '0 : idx_q + 1'b1;
                    state_d = (BLANK_TICKS == 0) ? StDrive : StBlank;
                end
                default: ;
            endcase
        end
    end

    // Latch new display data only when digit 0 is about to be shown, so a frame never tears.
    assign latch    = tick && (state_d == StDrive) && (idx_d == '0);
    assign sh_dig_d = latch ? bus.i_digits : sh_dig_q;
    assign sh_dp_d  = latch ? bus.i_dp : sh_dp_q;
    assign nibble   = sh_dig_d[{idx_d, 2'b00} +: 4];

    seg7_hex_decoder #(
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_dec (
        .i_nibble (nibble),
        .o_seg    (seg_dec)
    );

    always_comb begin
        anode_d  = anode_q;
        seg_d    = seg_q;
        dp_d     = dp_q;
        frame_d  = tick & wrap;
        anode_on = '0;
        if (tick) begin
            if (state_d == StDrive) begin
                // A masked digit keeps its slot and segment data, only the anode stays dark.
                anode_on[idx_d] = bus.i_enable[idx_d];
                anode_d         = ACTIVE_LOW ? ~anode_on : anode_on;
                seg_d           = seg_dec;
                dp_d            = sh_dp_d[idx_d] ^ ACTIVE_LOW;
            end else begin
                anode_d = AnodeOff;
                seg_d   = SegOff;
                dp_d    = DpOff;
            end
        end
    end

    assign bus.o_anode = anode_q;
    assign bus.o_seg   = seg_q;
    assign bus.o_dp    = dp_q;
    assign bus.o_frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: two configurations against a slot-arithmetic reference model.
module tb_seg7_scan_driver;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dc = 1'b0;
    logic [15:0] digits = 16'h3210;
    logic [3:0]  dpv = 4'b0010;
    logic [3:0]  en = 4'hF;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          chk_en = 1'b0;

    always #5 clk = ~clk;

    seg7_scan_driver_if #(.NUM_DIGITS(N)) bus_a ();
    seg7_scan_driver_if #(.NUM_DIGITS(N)) bus_b ();

    assign bus_a.i_delayClock = dc;
    assign bus_a.i_digits     = digits;
    assign bus_a.i_dp         = dpv;
    assign bus_a.i_enable     = en;
    assign bus_b.i_delayClock = dc;
    assign bus_b.i_digits     = digits;
    assign bus_b.i_dp         = dpv;
    assign bus_b.i_enable     = en;

    seg7_scan_driver #(.NUM_DIGITS(N), .BLANK_TICKS(1), .ACTIVE_LOW(1'b1)) dut_a (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_a)
    );

    seg7_scan_driver #(.NUM_DIGITS(N), .BLANK_TICKS(0), .ACTIVE_LOW(1'b0)) dut_b (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: outputs follow from the number of ticks since reset.
    int          bt [2] = '{1, 0};
    bit          al [2] = '{1'b1, 1'b0};
    logic [6:0]  hex_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    int          m_n [2];
    logic [15:0] m_sd [2];
    logic [3:0]  m_sp [2];
    logic [3:0]  m_an [2];
    logic [6:0]  m_seg [2];
    logic        m_dp [2];
    logic        m_fr [2];
    logic        prev_dc = 1'b0;

    initial begin
        int first, per, fp, s, d;
        logic [3:0] nib;
        logic [3:0] a_ah;
        logic       tk;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                prev_dc = 1'b0;
                for (int k = 0; k < 2; k++) begin
                    m_n[k]   = 0;
                    m_sd[k]  = '0;
                    m_sp[k]  = '0;
                    m_an[k]  = al[k] ? 4'hF : 4'h0;
                    m_seg[k] = al[k] ? 7'h7F : 7'h00;
                    m_dp[k]  = al[k];
                    m_fr[k]  = 1'b0;
                end
            end else begin
                tk = dc && !prev_dc;
                prev_dc = dc;
                for (int k = 0; k < 2; k++) begin
                    m_fr[k] = 1'b0;
                    if (tk) begin
                        first = (bt[k] == 0) ? 1 : bt[k];
                        per   = 1 + bt[k];
                        fp    = N * per;
                        if (m_n[k] >= first && ((m_n[k] - first) % fp) == (N - 1) * per)
                            m_fr[k] = 1'b1;
                        m_n[k]++;
                        s = (m_n[k] - first) % fp;
                        if (m_n[k] >= first && (s % per) == 0) begin
                            d = s / per;
                            if (d == 0) begin
                                m_sd[k] = digits;
                                m_sp[k] = dpv;
                            end
                            nib      = 4'((m_sd[k] >> (4 * d)) & 16'hF);
                            a_ah     = en[d] ? 4'(1 << d) : 4'h0;
                            m_an[k]  = al[k] ? ~a_ah : a_ah;
                            m_seg[k] = al[k] ? ~hex_tbl[nib] : hex_tbl[nib];
                            m_dp[k]  = m_sp[k][d] ^ al[k];
                        end else begin
                            m_an[k]  = al[k] ? 4'hF : 4'h0;
                            m_seg[k] = al[k] ? 7'h7F : 7'h00;
                            m_dp[k]  = al[k];
                        end
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("a_anode", bus_a.o_anode, m_an[0]);
                check("a_seg", bus_a.o_seg, m_seg[0]);
                check("a_dp", bus_a.o_dp, m_dp[0]);
                check("a_frame", bus_a.o_frame, m_fr[0]);
                check("b_anode", bus_b.o_anode, m_an[1]);
                check("b_seg", bus_b.o_seg, m_seg[1]);
                check("b_dp", bus_b.o_dp, m_dp[1]);
                check("b_frame", bus_b.o_frame, m_fr[1]);
            end
        end
    end

    // One scan tick: high for two cycles, low for one; frame sampled on both high cycles.
    task automatic do_tick(output logic [1:0] fa, output logic [1:0] fb);
        dc = 1'b1;
        @(negedge clk);
        fa[0] = bus_a.o_frame;
        fb[0] = bus_b.o_frame;
        @(negedge clk);
        fa[1] = bus_a.o_frame;
        fb[1] = bus_b.o_frame;
        dc = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [1:0] fa, fb;
        int hold;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_a_anode", bus_a.o_anode, 4'hF);
        check("rst_a_seg", bus_a.o_seg, 7'h7F);
        check("rst_b_anode", bus_b.o_anode, 4'h0);

        do_tick(fa, fb);  // 1
        check("t1_a_anode", bus_a.o_anode, 4'hE);
        check("t1_a_seg", bus_a.o_seg, 7'h40);
        check("t1_a_dp", bus_a.o_dp, 1'b1);
        check("t1_b_anode", bus_b.o_anode, 4'h1);
        check("t1_b_seg", bus_b.o_seg, 7'h3F);
        check("t1_b_dp", bus_b.o_dp, 1'b0);
        do_tick(fa, fb);  // 2
        check("t2_a_anode", bus_a.o_anode, 4'hF);
        check("t2_b_anode", bus_b.o_anode, 4'h2);
        check("t2_b_dp", bus_b.o_dp, 1'b1);
        do_tick(fa, fb);  // 3
        check("t3_a_anode", bus_a.o_anode, 4'hD);
        check("t3_a_seg", bus_a.o_seg, 7'h79);
        check("t3_a_dp", bus_a.o_dp, 1'b0);
        check("t3_b_anode", bus_b.o_anode, 4'h4);
        digits = 16'hFFFF;
        do_tick(fa, fb);  // 4
        check("t4_b_anode", bus_b.o_anode, 4'h8);
        check("t4_b_seg", bus_b.o_seg, 7'h4F);
        do_tick(fa, fb);  // 5
        check("t5_a_anode", bus_a.o_anode, 4'hB);
        check("t5_a_seg", bus_a.o_seg, 7'h24);
        check("t5_b_anode", bus_b.o_anode, 4'h1);
        check("t5_b_seg", bus_b.o_seg, 7'h71);
        check("t5_b_frame", fb, 2'b01);
        do_tick(fa, fb);  // 6
        do_tick(fa, fb);  // 7
        check("t7_a_anode", bus_a.o_anode, 4'h7);
        check("t7_a_seg", bus_a.o_seg, 7'h30);
        en = 4'b0101;
        do_tick(fa, fb);  // 8
        check("t8_a_frame", fa, 2'b01);
        do_tick(fa, fb);  // 9
        check("t9_a_anode", bus_a.o_anode, 4'hE);
        check("t9_a_seg", bus_a.o_seg, 7'h0E);
        do_tick(fa, fb);  // 10
        do_tick(fa, fb);  // 11
        check("t11_a_anode_masked", bus_a.o_anode, 4'hF);
        check("t11_a_seg_masked", bus_a.o_seg, 7'h0E);
        do_tick(fa, fb);  // 12
        do_tick(fa, fb);  // 13
        check("t13_a_anode", bus_a.o_anode, 4'hB);
        for (int i = 14; i <= 16; i++) do_tick(fa, fb);
        check("t16_a_frame", fa, 2'b01);

        dc = 1'b1;
        repeat (20) @(negedge clk);
        dc = 1'b0;
        @(negedge clk);
        check("hold_a_anode", bus_a.o_anode, 4'hE);
        for (int i = 0; i < 8; i++) begin
            dc = (i % 2 == 0);
            @(negedge clk);
        end
        check("toggle_a_anode", bus_a.o_anode, 4'hB);

        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_a_anode", bus_a.o_anode, 4'hF);
        check("arst_a_seg", bus_a.o_seg, 7'h7F);
        check("arst_a_dp", bus_a.o_dp, 1'b1);
        check("arst_a_frame", bus_a.o_frame, 1'b0);
        check("arst_b_anode", bus_b.o_anode, 4'h0);
        check("arst_b_seg", bus_b.o_seg, 7'h00);
        @(negedge clk);
        rst = 1'b0;
        digits = 16'h8888;
        en = 4'hF;
        do_tick(fa, fb);
        check("d8_b_anode", bus_b.o_anode, 4'h1);
        check("d8_b_seg", bus_b.o_seg, 7'h7F);
        check("d8_a_seg", bus_a.o_seg, 7'h00);

        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                dc = ~dc;
                hold = $urandom_range(0, 3);
            end else begin
                hold--;
            end
            if ($urandom_range(0, 39) == 0) digits = 16'($urandom);
            if ($urandom_range(0, 39) == 0) dpv = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 59) == 0) en = 4'($urandom_range(0, 15));
            if (i == 1500) #2 rst = 1'b1;
            if (i == 1504) rst = 1'b0;
            @(negedge clk);
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
